// File: rtl/morph3x3_bin_pkg.sv
// Shared image constants, state encoding and the 3x3 reduction helper
// for the binary morphology stage.
package morph3x3_bin_pkg;

   localparam int IMAGE_WIDTH_DEF  = 320;
   localparam int IMAGE_HEIGHT_DEF = 240;

   localparam logic [7:0] PIX_ON  = 8'd255;
   localparam logic [7:0] PIX_OFF = 8'd0;

   localparam int MORPH_ERODE  = 0;
   localparam int MORPH_DILATE = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } morph_state_e;

   // Erosion keeps a pixel only if all nine taps are set; dilation if any is.
   function automatic logic reduce9(input logic [8:0] taps, input int mode);
      logic res;
      if (mode == MORPH_DILATE) begin
         res = |taps;
      end else begin
         res = &taps;
      end
      return res;
   endfunction

endpackage

// File: rtl/morph3x3_bin_linebuf.sv
// One-bit line buffer: DEPTH flop-based cells, one shared address.
// The read returns the cell's content from before the same-cycle write.
module bin_linebuf #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [AW-1:0] addr,
   input  logic          wr_data,
   output logic          rd_data
);

   logic [DEPTH-1:0] mem;

   assign rd_data = mem[addr];

   // Storage cells; cleared on reset, one cell rewritten per enabled cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else if (en) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/morph3x3_bin.sv
// 3x3 binary erosion/dilation over a raster-order 0/255 pixel stream.
// One registered output per accepted pixel, delayed by W+1 pixels, plus a
// W+1 pixel flush of the bottom border after the final input of a frame.
module morph3x3_bin
   import morph3x3_bin_pkg::*;
#(
   parameter int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
   parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
   parameter int MODE         = MORPH_ERODE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bin_valid,
   input  logic [7:0]  bin_in,
   output logic        morph_valid,
   output logic [7:0]  morph_out,
   output logic [31:0] morph_row,
   output logic [31:0] morph_col,
   output logic        frame_done,
   output logic        frame_err
);

   localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
   localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   morph_state_e state, next_state;

   logic [CW-1:0] in_col, out_col;
   logic [RW-1:0] in_row, out_row;
   logic [2:0]    win_c0, win_c1, win_c2;
   logic          lb1_rd, lb2_rd;

   logic          b, accept, armed, emit, flush_emit, is_border, last_out, frame_end;
   logic [2:0]    new_col;
   logic          nxt_valid, nxt_done;
   logic [7:0]    nxt_pix;

   assign b       = |bin_in;
   assign new_col = {lb2_rd, lb1_rd, b};

   bin_linebuf #(.DEPTH(IMAGE_WIDTH), .AW(CW)) u_lb1 (
      .clk(clk), .rst_n(rst_n), .en(accept), .addr(in_col),
      .wr_data(b), .rd_data(lb1_rd)
   );

   bin_linebuf #(.DEPTH(IMAGE_WIDTH), .AW(CW)) u_lb2 (
      .clk(clk), .rst_n(rst_n), .en(accept), .addr(in_col),
      .wr_data(lb1_rd), .rd_data(lb2_rd)
   );

   // Datapath decode: which cycles accept, emit, and what the result is.
   always_comb begin
      accept     = bin_valid && (state != ST_FLUSH);
      armed      = (in_row > ROW_ONE) || ((in_row == ROW_ONE) && (in_col != '0));
      flush_emit = (state == ST_FLUSH);
      emit       = (accept && armed) || flush_emit;
      is_border  = (out_row == '0) || (out_row == LAST_ROW) ||
                   (out_col == '0) || (out_col == LAST_COL);
      last_out   = (out_row == LAST_ROW) && (out_col == LAST_COL);
      frame_end  = flush_emit && last_out;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: frame starts on first accept, flushes after the last.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               next_state = ST_STREAM;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (accept && (in_row == LAST_ROW) && (in_col == LAST_COL)) begin
               next_state = ST_FLUSH;
            end else begin
               next_state = ST_STREAM;
            end
         end
         ST_FLUSH: begin
            if (last_out) begin
               next_state = ST_IDLE;
            end else begin
               next_state = ST_FLUSH;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Output decode: border pixels are forced off, interior uses the 9 taps.
   always_comb begin
      nxt_valid = emit;
      nxt_done  = frame_end;
      nxt_pix   = PIX_OFF;
      if (emit && !is_border && reduce9({win_c1, win_c2, new_col}, MODE)) begin
         nxt_pix = PIX_ON;
      end else begin
         nxt_pix = PIX_OFF;
      end
   end

   // Input/output pixel counters; all return to zero when a frame completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_col  <= '0;
         in_row  <= '0;
         out_col <= '0;
         out_row <= '0;
      end else if (frame_end) begin
         in_col  <= '0;
         in_row  <= '0;
         out_col <= '0;
         out_row <= '0;
      end else begin
         if (accept) begin
            if (in_col == LAST_COL) begin
               in_col <= '0;
               in_row <= (in_row == LAST_ROW) ? '0 : in_row + ROW_ONE;
            end else begin
               in_col <= in_col + COL_ONE;
            end
         end
         if (emit) begin
            if (out_col == LAST_COL) begin
               out_col <= '0;
               out_row <= (out_row == LAST_ROW) ? '0 : out_row + ROW_ONE;
            end else begin
               out_col <= out_col + COL_ONE;
            end
         end
      end
   end

   // 3x3 window: shift left one column per accepted pixel, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_c0 <= '0;
         win_c1 <= '0;
         win_c2 <= '0;
      end else if (accept) begin
         win_c0 <= win_c1;
         win_c1 <= win_c2;
         win_c2 <= new_col;
      end
   end

   // Registered outputs; coordinates follow the output counters on emit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         morph_valid <= 1'b0;
         morph_out   <= PIX_OFF;
         morph_row   <= 32'd0;
         morph_col   <= 32'd0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         morph_valid <= nxt_valid;
         morph_out   <= nxt_pix;
         frame_done  <= nxt_done;
         frame_err   <= frame_err | (bin_valid && (state == ST_FLUSH));
         if (emit) begin
            morph_row <= 32'(out_row);
            morph_col <= 32'(out_col);
         end
      end
   end

endmodule

// File: tb/tb_morph3x3_bin.sv
// Scoreboard bench for morph3x3_bin: an erosion and a dilation instance
// see the same stream; expected frames come from a direct 3x3 neighbourhood model.
module tb_morph3x3_bin;

   localparam int W = 8;
   localparam int H = 6;

   typedef struct {
      int         row;
      int         col;
      logic [7:0] pix;
      logic       done;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bin_valid = 1'b0;
   logic [7:0]  bin_in = 8'd0;

   logic        mv_e, fd_e, fe_e, mv_d, fd_d, fe_d;
   logic [7:0]  mo_e, mo_d;
   logic [31:0] mr_e, mc_e, mr_d, mc_d;

   exp_t        q_e[$];
   exp_t        q_d[$];
   logic [7:0]  frame_pix[W*H];
   int          n_pass = 0;
   int          n_total = 0;
   logic        drove_prev = 1'b0;
   logic        stream_phase = 1'b0;

   morph3x3_bin #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .MODE(0)) dut_e (
      .clk(clk), .rst_n(rst_n), .bin_valid(bin_valid), .bin_in(bin_in),
      .morph_valid(mv_e), .morph_out(mo_e), .morph_row(mr_e), .morph_col(mc_e),
      .frame_done(fd_e), .frame_err(fe_e)
   );

   morph3x3_bin #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .MODE(1)) dut_d (
      .clk(clk), .rst_n(rst_n), .bin_valid(bin_valid), .bin_in(bin_in),
      .morph_valid(mv_d), .morph_out(mo_d), .morph_row(mr_d), .morph_col(mc_d),
      .frame_done(fd_d), .frame_err(fe_d)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint req);
      n_total++;
      if (act == req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Remember whether a pixel was offered at each rising edge.
   always @(posedge clk) drove_prev <= bin_valid;

   // Erosion monitor.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && mv_e) begin
         check("erode_extra_output", q_e.size() > 0, 1);
         if (q_e.size() > 0) begin
            e = q_e.pop_front();
            check("erode_row", mr_e, e.row);
            check("erode_col", mc_e, e.col);
            check("erode_pix", mo_e, e.pix);
            check("erode_done", fd_e, e.done);
         end
         if (stream_phase) check("erode_gap_output", drove_prev, 1);
      end else if (rst_n && fd_e) begin
         check("erode_done_needs_valid", mv_e, fd_e);
      end
   end

   // Dilation monitor.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && mv_d) begin
         check("dilate_extra_output", q_d.size() > 0, 1);
         if (q_d.size() > 0) begin
            e = q_d.pop_front();
            check("dilate_row", mr_d, e.row);
            check("dilate_col", mc_d, e.col);
            check("dilate_pix", mo_d, e.pix);
            check("dilate_done", fd_d, e.done);
         end
         if (stream_phase) check("dilate_gap_output", drove_prev, 1);
      end else if (rst_n && fd_d) begin
         check("dilate_done_needs_valid", mv_d, fd_d);
      end
   end

   // kind 0: all 255; kind 1: single pixel at (2,3); kind 2: random bits.
   task automatic make_frame(input int kind);
      for (int i = 0; i < W*H; i++) begin
         case (kind)
            0:       frame_pix[i] = 8'd255;
            1:       frame_pix[i] = (i == 2*W + 3) ? 8'd255 : 8'd0;
            default: frame_pix[i] = ($urandom_range(0, 99) < 75) ?
                                    8'($urandom_range(1, 255)) : 8'd0;
         endcase
      end
   endtask

   // Reference: every pixel of the frame in raster order, neighbourhood rule.
   task automatic push_expected();
      exp_t e;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            int ones;
            ones = 0;
            if (r > 0 && r < H-1 && c > 0 && c < W-1) begin
               for (int dr = -1; dr <= 1; dr++)
                  for (int dc = -1; dc <= 1; dc++)
                     if (frame_pix[(r+dr)*W + (c+dc)] != 8'd0) ones++;
            end
            e.row  = r;
            e.col  = c;
            e.done = (r == H-1) && (c == W-1);
            e.pix  = (ones == 9) ? 8'd255 : 8'd0;
            q_e.push_back(e);
            e.pix  = (ones > 0) ? 8'd255 : 8'd0;
            q_d.push_back(e);
         end
      end
   endtask

   // Drive the first n pixels of the frame, inserting random idle cycles.
   task automatic drive_pixels(input int n, input int gap_pct);
      stream_phase = 1'b1;
      for (int i = 0; i < n; i++) begin
         while (int'($urandom_range(0, 99)) < gap_pct) begin
            bin_valid = 1'b0;
            bin_in    = 8'($urandom);
            @(negedge clk);
         end
         bin_valid = 1'b1;
         bin_in    = frame_pix[i];
         @(negedge clk);
      end
      bin_valid    = 1'b0;
      bin_in       = 8'd0;
      stream_phase = 1'b0;
   endtask

   // Flush must be W+1 back-to-back outputs, then silence; optional stray pixel.
   task automatic flush_check(input bit err_pulse);
      for (int k = 1; k <= W+1; k++) begin
         bin_valid = (err_pulse && k == 3);
         bin_in    = 8'd255;
         @(negedge clk);
         check("erode_flush_valid", mv_e, 1);
         check("dilate_flush_valid", mv_d, 1);
      end
      bin_valid = 1'b0;
      bin_in    = 8'd0;
      @(negedge clk);
      check("erode_after_flush_idle", mv_e, 0);
      check("dilate_after_flush_idle", mv_d, 0);
      check("erode_queue_drained", q_e.size(), 0);
      check("dilate_queue_drained", q_d.size(), 0);
      repeat (W+3) @(negedge clk);
   endtask

   task automatic run_frame(input int kind, input int gap_pct, input bit err_pulse);
      make_frame(kind);
      push_expected();
      drive_pixels(W*H, gap_pct);
      flush_check(err_pulse);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_erode_valid"}, mv_e, 0);
      check({tag, "_erode_out"},   mo_e, 0);
      check({tag, "_erode_row"},   mr_e, 0);
      check({tag, "_erode_col"},   mc_e, 0);
      check({tag, "_erode_done"},  fd_e, 0);
      check({tag, "_erode_err"},   fe_e, 0);
      check({tag, "_dilate_valid"}, mv_d, 0);
      check({tag, "_dilate_out"},   mo_d, 0);
      check({tag, "_dilate_row"},   mr_d, 0);
      check({tag, "_dilate_col"},   mc_d, 0);
      check({tag, "_dilate_done"},  fd_d, 0);
      check({tag, "_dilate_err"},   fe_d, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_frame(0, 0, 1'b0);     // all 255, continuous
      run_frame(1, 0, 1'b0);     // single pixel at (2,3)
      run_frame(0, 50, 1'b0);    // all 255, gapped
      run_frame(2, 40, 1'b0);    // random image, gapped
      check("erode_err_clear", fe_e, 0);
      check("dilate_err_clear", fe_d, 0);

      run_frame(2, 0, 1'b1);     // stray pixel during flush
      check("erode_err_set", fe_e, 1);
      check("dilate_err_set", fe_d, 1);
      run_frame(2, 30, 1'b0);    // next frame still processed
      check("erode_err_sticky", fe_e, 1);
      check("dilate_err_sticky", fe_d, 1);

      // Abort mid-row 3 with an asynchronous reset.
      make_frame(0);
      push_expected();
      drive_pixels(3*W + 4, 0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      q_e.delete();
      q_d.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_frame(0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
